sdram_pattern_tester: RTL

Parametrised SDRAM exercise engine that drives the Avalon-MM write-master and read-master control/user ports of the Qsys SDRAM subsystem. Supports peek-mode single-word reads for the board's hex display. Fills a word region with a selectable pattern, reads it back, compares on the fly, and reports mismatch count and first failing address. Replaces the fixed-width user logic with configurable address/data widths, lengths and modes.

---
 rtl/sdram_pattern_tester.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_pattern_tester.sv
// Fill/verify/peek exercise engine driving the Qsys SDRAM write-master and read-master ports.
// Define SDRAM_TESTER_ERRINJ_EN to add inject_err, which corrupts bit 0 of fill word 0.
module sdram_pattern_tester #(
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = 32,
  parameter int ERRW         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    pattern_sel,
`ifdef SDRAM_TESTER_ERRINJ_EN
  input  logic                    inject_err,
`endif
  input  logic [ADDRESSWIDTH-1:0] base_addr,
  input  logic [ADDRESSWIDTH-1:0] word_count,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERRW-1:0]         err_count,
  output logic [ADDRESSWIDTH-1:0] first_err_addr,
  output logic [DATAWIDTH-1:0]    peek_data,
  output logic                    write_control_fixed_location,
  output logic [ADDRESSWIDTH-1:0] write_control_write_base,
  output logic [ADDRESSWIDTH-1:0] write_control_write_length,
  output logic                    write_control_go,
  input  logic                    write_control_done,
  output logic                    write_user_write_buffer,
  output logic [DATAWIDTH-1:0]    write_user_buffer_data,
  input  logic                    write_user_buffer_full,
  output logic                    read_control_fixed_location,
  output logic [ADDRESSWIDTH-1:0] read_control_read_base,
  output logic [ADDRESSWIDTH-1:0] read_control_read_length,
  output logic                    read_control_go,
  input  logic                    read_control_done,
  output logic                    read_user_read_buffer,
  input  logic [DATAWIDTH-1:0]    read_user_buffer_output_data,
  input  logic                    read_user_data_available
);

  localparam int                    BPW        = DATAWIDTH / 8;
  localparam int                    REP        = DATAWIDTH / 32;
  localparam logic [ADDRESSWIDTH-1:0] BPW_A    = ADDRESSWIDTH'(BPW);
  localparam logic [31:0]           LFSR_SEED  = 32'hACE1_0001;
  localparam logic [31:0]           LFSR_TAPS  = 32'h8020_0003;
  localparam logic [1:0]            MODE_FV    = 2'b00;
  localparam logic [1:0]            MODE_PEEK  = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_GO    = 3'd1,
    WR_FILL  = 3'd2,
    WR_WAIT  = 3'd3,
    RD_GO    = 3'd4,
    RD_DRAIN = 3'd5,
    RD_WAIT  = 3'd6,
    FINISH   = 3'd7
  } state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  function automatic logic [DATAWIDTH-1:0] pattern_word(input logic sel,
                                                        input logic [ADDRESSWIDTH-1:0] a,
                                                        input logic [31:0] l);
    if (sel) return {REP{l}};
    else     return DATAWIDTH'(a);
  endfunction

  state_t                  state_r;
  logic [1:0]              mode_r;
  logic                    pat_r;
  logic [ADDRESSWIDTH-1:0] base_r, count_r;
  logic [ADDRESSWIDTH-1:0] wr_left_r, wr_addr_r, rd_left_r, rd_addr_r, cmp_addr_r;
  logic [31:0]             wr_lfsr_r, rd_lfsr_r;
  logic [DATAWIDTH-1:0]    wr_data_r;
  logic                    wr_done_seen_r, rd_done_seen_r, cmp_vld_r, cmp_bad_r;
  logic                    push_s, pop_s, inj_s;
  logic [ADDRESSWIDTH-1:0] start_cnt_s;
  logic [DATAWIDTH-1:0]    exp_s, first_word_s;

`ifdef SDRAM_TESTER_ERRINJ_EN
  assign inj_s = inject_err;
`else
  assign inj_s = 1'b0;
`endif

  // Flow-control strobes must react to full/available in the same cycle, so they are gated live.
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    if (state_r == WR_FILL && !write_user_buffer_full && wr_left_r != '0) push_s = 1'b1;
    else                                                                   push_s = 1'b0;
    if (state_r == RD_DRAIN && read_user_data_available && rd_left_r != '0) pop_s = 1'b1;
    else                                                                     pop_s = 1'b0;
    if (mode == MODE_PEEK) start_cnt_s = ADDRESSWIDTH'(1);
    else                   start_cnt_s = word_count;
    exp_s        = pattern_word(pat_r, rd_addr_r, rd_lfsr_r);
    first_word_s = pattern_word(pattern_sel, base_addr, LFSR_SEED) ^ {{(DATAWIDTH-1){1'b0}}, inj_s};
  end

  assign write_user_write_buffer      = push_s;
  assign read_user_read_buffer        = pop_s;
  assign write_user_buffer_data       = wr_data_r;
  assign write_control_fixed_location = 1'b0;
  assign read_control_fixed_location  = 1'b0;

  // Sequencer, address/LFSR generators, one-stage compare pipe and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      mode_r <= 2'b00; pat_r <= 1'b0; base_r <= '0; count_r <= '0;
      wr_left_r <= '0; wr_addr_r <= '0; wr_lfsr_r <= 32'h0; wr_data_r <= '0;
      rd_left_r <= '0; rd_addr_r <= '0; rd_lfsr_r <= 32'h0;
      cmp_addr_r <= '0; cmp_vld_r <= 1'b0; cmp_bad_r <= 1'b0;
      wr_done_seen_r <= 1'b0; rd_done_seen_r <= 1'b0;
      busy <= 1'b0; done <= 1'b0; pass <= 1'b0;
      err_count <= '0; first_err_addr <= '0; peek_data <= '0;
      write_control_write_base <= '0; write_control_write_length <= '0; write_control_go <= 1'b0;
      read_control_read_base <= '0; read_control_read_length <= '0; read_control_go <= 1'b0;
    end else begin
      done             <= 1'b0;
      write_control_go <= 1'b0;
      read_control_go  <= 1'b0;
      cmp_vld_r        <= 1'b0;
      if (cmp_vld_r && cmp_bad_r) begin
        if (err_count == '0) first_err_addr <= cmp_addr_r;
        if (err_count != '1) err_count <= err_count + ERRW'(1);
      end
      // Master done pulses may arrive before we reach the wait state; remember them.
      if ((state_r == WR_GO || state_r == WR_FILL || state_r == WR_WAIT) && write_control_done)
        wr_done_seen_r <= 1'b1;
      if ((state_r == RD_GO || state_r == RD_DRAIN || state_r == RD_WAIT) && read_control_done)
        rd_done_seen_r <= 1'b1;

      case (state_r)
        IDLE: begin
          if (start) begin
            busy <= 1'b1; pass <= 1'b0; err_count <= '0; first_err_addr <= '0;
            mode_r <= mode; pat_r <= pattern_sel; base_r <= base_addr; count_r <= start_cnt_s;
            wr_done_seen_r <= 1'b0; rd_done_seen_r <= 1'b0;
            write_control_write_base   <= base_addr;
            read_control_read_base     <= base_addr;
            write_control_write_length <= start_cnt_s * BPW_A;
            read_control_read_length   <= start_cnt_s * BPW_A;
            if (start_cnt_s == '0) begin
              state_r <= FINISH;
            end else if (mode[1]) begin
              state_r <= RD_GO; read_control_go <= 1'b1;
              rd_left_r <= start_cnt_s; rd_addr_r <= base_addr; rd_lfsr_r <= LFSR_SEED;
            end else begin
              state_r <= WR_GO; write_control_go <= 1'b1;
              wr_left_r <= word_count; wr_addr_r <= base_addr; wr_lfsr_r <= LFSR_SEED;
              wr_data_r <= first_word_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WR_GO: state_r <= WR_FILL;
        WR_FILL: begin
          if (push_s) begin
            wr_left_r <= wr_left_r - ADDRESSWIDTH'(1);
            wr_addr_r <= wr_addr_r + BPW_A;
            wr_lfsr_r <= lfsr_next(wr_lfsr_r);
            wr_data_r <= pattern_word(pat_r, wr_addr_r + BPW_A, lfsr_next(wr_lfsr_r));
            if (wr_left_r == ADDRESSWIDTH'(1)) state_r <= WR_WAIT;
            else                               state_r <= WR_FILL;
          end else begin
            state_r <= WR_FILL;
          end
        end
        WR_WAIT: begin
          if (wr_done_seen_r || write_control_done) begin
            wr_done_seen_r <= 1'b0;
            if (mode_r == MODE_FV) begin
              state_r <= RD_GO; read_control_go <= 1'b1; rd_done_seen_r <= 1'b0;
              rd_left_r <= count_r; rd_addr_r <= base_r; rd_lfsr_r <= LFSR_SEED;
            end else begin
              state_r <= FINISH;
            end
          end else begin
            state_r <= WR_WAIT;
          end
        end
        RD_GO: state_r <= RD_DRAIN;
        RD_DRAIN: begin
          if (pop_s) begin
            if (mode_r == MODE_PEEK) begin
              peek_data <= read_user_buffer_output_data;
            end else begin
              cmp_vld_r  <= 1'b1;
              cmp_bad_r  <= (read_user_buffer_output_data != exp_s);
              cmp_addr_r <= rd_addr_r;
            end
            rd_left_r <= rd_left_r - ADDRESSWIDTH'(1);
            rd_addr_r <= rd_addr_r + BPW_A;
            rd_lfsr_r <= lfsr_next(rd_lfsr_r);
            if (rd_left_r == ADDRESSWIDTH'(1)) state_r <= RD_WAIT;
            else                               state_r <= RD_DRAIN;
          end else begin
            state_r <= RD_DRAIN;
          end
        end
        RD_WAIT: begin
          if ((rd_done_seen_r || read_control_done) && !cmp_vld_r) begin
            rd_done_seen_r <= 1'b0;
            state_r        <= FINISH;
          end else begin
            state_r <= RD_WAIT;
          end
        end
        FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          pass    <= (err_count == '0);
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
